reorder_buffer: RTL and testbench



---
 rtl/reorder_buffer_pkg.sv | 13 +
 rtl/reorder_buffer.sv | 160 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer: sizing and the tag/slot mapping.
package rob_pkg;

  localparam int unsigned TAG_W    = 3;
  localparam int unsigned ENTRIES  = (1 << TAG_W) - 1;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned RD_W     = 5;

  // Tag 0 means "no dependency"; slot i carries tag i + TAG_BASE.
  localparam int unsigned TAG_NONE = 0;
  localparam int unsigned TAG_BASE = 1;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates rename tags, captures results by tag,
// retires one ready head entry per cycle as a registered commit pulse and
// answers two combinational forwarding queries.
module reorder_buffer #(
  parameter int unsigned TAG_W   = rob_pkg::TAG_W,
  parameter int unsigned ENTRIES = rob_pkg::ENTRIES,
  parameter int unsigned XLEN    = rob_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [rob_pkg::RD_W-1:0] issue_rd,
  output logic                     issue_ready,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic                     wb_valid,
  input  logic [TAG_W-1:0]         wb_tag,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     flush,
  input  logic [TAG_W-1:0]         q1_tag,
  output logic                     q1_ready,
  output logic [XLEN-1:0]          q1_value,
  input  logic [TAG_W-1:0]         q2_tag,
  output logic                     q2_ready,
  output logic [XLEN-1:0]          q2_value,
  output logic                     commit,
  output logic [rob_pkg::RD_W-1:0] reg_num,
  output logic [XLEN-1:0]          data_in,
  output logic [TAG_W-1:0]         num_in
);
  import rob_pkg::RD_W;
  import rob_pkg::TAG_NONE;
  import rob_pkg::TAG_BASE;

  typedef logic [TAG_W-1:0] ptr_t;

  localparam ptr_t LAST = ptr_t'(ENTRIES - 1);
  localparam ptr_t FULL = ptr_t'(ENTRIES);
  localparam ptr_t ONE  = ptr_t'(TAG_BASE);
  localparam ptr_t NONE = ptr_t'(TAG_NONE);

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [ENTRIES-1:0] ready_q, ready_d;
  logic [RD_W-1:0]    rd_q    [ENTRIES];
  logic [RD_W-1:0]    rd_d    [ENTRIES];
  logic [XLEN-1:0]    value_q [ENTRIES];
  logic [XLEN-1:0]    value_d [ENTRIES];
  ptr_t               head_q, head_d;
  ptr_t               tail_q, tail_d;
  ptr_t               count_q, count_d;
  logic               commit_q, commit_d;
  logic [RD_W-1:0]    reg_num_q, reg_num_d;
  logic [XLEN-1:0]    data_q, data_d;
  ptr_t               num_q, num_d;

  logic do_issue, do_retire, do_wb;
  ptr_t wb_idx, q1_idx, q2_idx;

  function automatic ptr_t wrap_inc(input ptr_t p);
    return (p == LAST) ? '0 : p + ONE;
  endfunction

  assign issue_ready = (count_q != FULL);
  assign alloc_tag   = tail_q + ONE;
  assign do_issue    = issue_valid && issue_ready;
  // Retire decision uses registered ready, so a same-cycle writeback to the head waits one edge.
  assign do_retire   = (count_q != '0) && busy_q[head_q] && ready_q[head_q];
  assign wb_idx      = wb_tag - ONE;
  assign do_wb       = wb_valid && (wb_tag != NONE) && busy_q[wb_idx];

  assign q1_idx   = q1_tag - ONE;
  assign q2_idx   = q2_tag - ONE;
  assign q1_ready = (q1_tag != NONE) && busy_q[q1_idx] && ready_q[q1_idx];
  assign q2_ready = (q2_tag != NONE) && busy_q[q2_idx] && ready_q[q2_idx];
  assign q1_value = q1_ready ? value_q[q1_idx] : '0;
  assign q2_value = q2_ready ? value_q[q2_idx] : '0;

  assign commit  = commit_q;
  assign reg_num = reg_num_q;
  assign data_in = data_q;
  assign num_in  = num_q;

  // Next-state: flush clears occupancy; otherwise writeback, retire and issue in that order.
  always_comb begin
    busy_d    = busy_q;
    ready_d   = ready_q;
    rd_d      = rd_q;
    value_d   = value_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    commit_d  = 1'b0;
    reg_num_d = reg_num_q;
    data_d    = data_q;
    num_d     = num_q;
    if (flush) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_wb) begin
        ready_d[wb_idx] = 1'b1;
        value_d[wb_idx] = wb_data;
      end
      if (do_retire) begin
        commit_d        = 1'b1;
        reg_num_d       = rd_q[head_q];
        data_d          = value_q[head_q];
        num_d           = head_q + ONE;
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = wrap_inc(head_q);
      end
      if (do_issue) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        rd_d[tail_q]    = issue_rd;
        tail_d          = wrap_inc(tail_q);
      end
      case ({do_issue, do_retire})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      ready_q   <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      commit_q  <= 1'b0;
      reg_num_q <= '0;
      data_q    <= '0;
      num_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      rd_q      <= rd_d;
      value_q   <= value_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      commit_q  <= commit_d;
      reg_num_q <= reg_num_d;
      data_q    <= data_d;
      num_q     <= num_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios with literal
// expectations, then randomized traffic checked against a queue-based model.
module tb_reorder_buffer;

  localparam int NE = 7;

  logic        clk = 1'b0;
  logic        rst, issue_valid, wb_valid, flush;
  logic [4:0]  issue_rd;
  logic [2:0]  wb_tag, q1_tag, q2_tag;
  logic [31:0] wb_data;
  logic        issue_ready, q1_ready, q2_ready, commit;
  logic [2:0]  alloc_tag, num_in;
  logic [31:0] q1_value, q2_value, data_in;
  logic [4:0]  reg_num;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  reorder_buffer #(.TAG_W(3), .ENTRIES(7), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .flush(flush),
    .q1_tag(q1_tag), .q1_ready(q1_ready), .q1_value(q1_value),
    .q2_tag(q2_tag), .q2_ready(q2_ready), .q2_value(q2_value),
    .commit(commit), .reg_num(reg_num), .data_in(data_in), .num_in(num_in)
  );

  // Model: program-ordered queue of in-flight instructions.
  typedef struct {
    int unsigned tag;
    logic [4:0]  rd;
    bit          rdy;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_next = 1;
  bit          m_commit = 1'b0;
  logic [4:0]  m_reg = '0;
  logic [31:0] m_data = '0;
  int unsigned m_num = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] fwd(input logic [2:0] t);
    logic [32:0] r;
    r = '0;
    if (t != 3'd0)
      foreach (mq[i])
        if (mq[i].tag == int'(t) && mq[i].rdy) r = {1'b1, mq[i].val};
    return r;
  endfunction

  always @(posedge clk) begin : mdl
    bit   ret, iss;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_next = 1; m_commit = 0; m_reg = '0; m_data = '0; m_num = 0;
    end else if (flush) begin
      mq.delete();
      m_next = 1; m_commit = 0;
    end else begin
      ret = (mq.size() > 0) && mq[0].rdy;
      iss = issue_valid && (mq.size() < NE);
      m_commit = ret;
      if (ret) begin
        m_reg = mq[0].rd; m_data = mq[0].val; m_num = mq[0].tag;
      end
      if (wb_valid && wb_tag != 3'd0)
        foreach (mq[i])
          if (mq[i].tag == int'(wb_tag)) begin
            e = mq[i]; e.rdy = 1'b1; e.val = wb_data; mq[i] = e;
          end
      if (ret) void'(mq.pop_front());
      if (iss) begin
        e.tag = m_next; e.rd = issue_rd; e.rdy = 1'b0; e.val = '0;
        mq.push_back(e);
        m_next = (m_next == NE) ? 1 : m_next + 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [32:0] f1, f2;
    if (chk_en) begin
      f1 = fwd(q1_tag);
      f2 = fwd(q2_tag);
      chk("m_issue_ready", issue_ready, mq.size() != NE);
      chk("m_alloc_tag", alloc_tag, m_next);
      chk("m_commit", commit, m_commit);
      chk("m_reg_num", reg_num, m_reg);
      chk("m_data_in", data_in, m_data);
      chk("m_num_in", num_in, m_num);
      chk("m_q1_ready", q1_ready, f1[32]);
      chk("m_q1_value", q1_value, f1[31:0]);
      chk("m_q2_ready", q2_ready, f2[32]);
      chk("m_q2_value", q2_value, f2[31:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    issue_valid = 0; wb_valid = 0; flush = 0;
  endtask

  task automatic iss(input logic [4:0] rd);
    issue_valid = 1; issue_rd = rd;
  endtask

  task automatic wb(input logic [2:0] t, input logic [31:0] d);
    wb_valid = 1; wb_tag = t; wb_data = d;
  endtask

  task automatic do_reset();
    idle();
    q1_tag = 0; q2_tag = 0;
    rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    rst = 1; issue_valid = 0; issue_rd = 0; wb_valid = 0; wb_tag = 0;
    wb_data = 0; flush = 0; q1_tag = 0; q2_tag = 0;

    // 1: basic issue and single commit
    do_reset();
    chk_en = 1;
    chk("t1_rst_ready", issue_ready, 1);
    chk("t1_rst_alloc", alloc_tag, 1);
    chk("t1_rst_commit", commit, 0);
    chk("t1_rst_regnum", reg_num, 0);
    chk("t1_rst_data", data_in, 0);
    chk("t1_rst_num", num_in, 0);
    iss(5); chk("t1_alloc1", alloc_tag, 1); tick();
    iss(6); chk("t1_alloc2", alloc_tag, 2); tick();
    idle(); chk("t1_alloc3", alloc_tag, 3);
    wb(1, 32'hDEADBEEF); tick(); idle();
    chk("t1_no_commit_yet", commit, 0);
    tick();
    chk("t1_commit", commit, 1);
    chk("t1_regnum", reg_num, 5);
    chk("t1_data", data_in, 32'hDEADBEEF);
    chk("t1_num", num_in, 1);
    tick();
    chk("t1_pulse_end", commit, 0);
    chk("t1_regnum_hold", reg_num, 5);

    // 2: out-of-order completion retires in order
    do_reset();
    iss(1); tick(); iss(2); tick(); iss(3); tick(); idle();
    wb(3, 32'h33); tick(); idle(); chk("t2_wait3", commit, 0);
    wb(2, 32'h22); tick(); idle(); chk("t2_wait2", commit, 0);
    wb(1, 32'h11); tick(); idle(); chk("t2_wait1", commit, 0);
    tick(); chk("t2_c1", commit, 1); chk("t2_n1", num_in, 1); chk("t2_d1", data_in, 32'h11);
    tick(); chk("t2_c2", commit, 1); chk("t2_n2", num_in, 2); chk("t2_d2", data_in, 32'h22);
    tick(); chk("t2_c3", commit, 1); chk("t2_n3", num_in, 3); chk("t2_d3", data_in, 32'h33);
    tick(); chk("t2_end", commit, 0);

    // 3: full, wrap, simultaneous issue and retire
    do_reset();
    for (int i = 0; i < NE; i++) begin
      iss(5'(i + 8)); tick();
    end
    idle();
    chk("t3_full", issue_ready, 0);
    chk("t3_full_alloc", alloc_tag, 1);
    iss(20); tick(); idle();
    chk("t3_still_full", issue_ready, 0);
    wb(1, 32'hA1); tick(); idle();
    chk("t3_no_commit", commit, 0);
    tick();
    chk("t3_commit", commit, 1);
    chk("t3_num", num_in, 1);
    chk("t3_regnum", reg_num, 8);
    chk("t3_ready_again", issue_ready, 1);
    chk("t3_wrap_alloc", alloc_tag, 1);
    wb(2, 32'hA2); tick(); idle();
    iss(21); tick(); idle();
    chk("t3_sim_commit", commit, 1);
    chk("t3_sim_num", num_in, 2);
    chk("t3_sim_ready", issue_ready, 1);
    chk("t3_sim_alloc", alloc_tag, 2);
    iss(22); tick(); idle();
    chk("t3_refull", issue_ready, 0);

    // 4: forwarding queries
    do_reset();
    iss(3); tick(); iss(4); tick(); idle();
    wb(1, 32'h55); tick(); idle();
    q1_tag = 1; q2_tag = 0; #1;
    chk("t4_q1_ready", q1_ready, 1);
    chk("t4_q1_value", q1_value, 32'h55);
    chk("t4_q2_tag0_ready", q2_ready, 0);
    chk("t4_q2_tag0_value", q2_value, 0);
    q2_tag = 2; #1;
    chk("t4_q2_unwritten_ready", q2_ready, 0);
    chk("t4_q2_unwritten_value", q2_value, 0);
    q1_tag = 0; q2_tag = 0;

    // 5: stale and tag-0 writebacks are ignored
    do_reset();
    iss(7); tick(); idle();
    wb(4, 32'h99); tick(); idle();
    chk("t5_stale_commit", commit, 0);
    q1_tag = 4; #1; chk("t5_stale_q", q1_ready, 0);
    wb(0, 32'h77); tick(); idle();
    chk("t5_tag0_commit", commit, 0);
    q1_tag = 1; #1; chk("t5_head_not_ready", q1_ready, 0);
    tick(); chk("t5_no_commit", commit, 0);
    q1_tag = 0;

    // 6: flush with a ready head
    do_reset();
    for (int i = 0; i < 4; i++) begin
      iss(5'(i + 1)); tick();
    end
    idle();
    wb(1, 32'hF1); tick(); idle();
    flush = 1; tick(); flush = 0;
    chk("t6_commit", commit, 0);
    chk("t6_ready", issue_ready, 1);
    chk("t6_alloc", alloc_tag, 1);
    q1_tag = 1; #1; chk("t6_q1_cleared", q1_ready, 0);
    wb(2, 32'hF2); tick(); idle();
    q1_tag = 2; #1; chk("t6_old_tag_ignored", q1_ready, 0);
    tick(); chk("t6_no_commit", commit, 0);
    q1_tag = 0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_rd    = 5'($urandom);
      wb_valid    = ($urandom_range(0, 9) < 5);
      wb_tag      = 3'($urandom_range(0, 7));
      wb_data     = $urandom;
      flush       = ($urandom_range(0, 99) < 2);
      rst         = ($urandom_range(0, 199) == 0);
      q1_tag      = 3'($urandom_range(0, 7));
      q2_tag      = 3'($urandom_range(0, 7));
      tick();
    end
    idle(); rst = 0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
